// File: rtl/mcs4_pkg.sv
// MCS-4 bus types shared by the ROM sequencer, its arbiter and observers.
package mcs4;

   typedef enum logic [2:0] {
      A1 = 3'd0,
      A2 = 3'd1,
      A3 = 3'd2,
      M1 = 3'd3,
      M2 = 3'd4,
      X1 = 3'd5,
      X2 = 3'd6,
      X3 = 3'd7
   } instr_cyc_t;

   typedef logic [3:0]  char_t;
   typedef logic [7:0]  byte_t;
   typedef logic [11:0] rom_addr_t;

   localparam int Cycle_len = 8;
   localparam int Max_roms  = 16;

   function automatic char_t chip_of(input rom_addr_t a);
      return a[11:8];
   endfunction

endpackage

// File: rtl/mcs4_rr_arbiter.sv
// Two-port fetch arbiter: round-robin on ties (RR_EN=1) or fixed port-0 priority.
// Latency: combinational grant; pointer moves on the clock edge closing an enabled grant.
// Backpressure: losers see no grant and must keep requesting.
module mcs4_rr_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic       gnt_vld,
   output logic       gnt_id
);

   logic last_q;

   always_comb begin
      gnt_vld = |req;
      if (req == 2'b11) begin
         gnt_id = RR_EN ? ~last_q : 1'b0;
      end else begin
         gnt_id = ~req[0];
      end
   end

   // Pointer starts at 1 so port 0 wins the first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (en && gnt_vld) begin
         last_q <= gnt_id;
      end
   end

endmodule

// File: rtl/mcs4_rom_sequencer.sv
// MCS-4 ROM bus master: 8-phase cycle, sync, one arbitrated fetch per instruction cycle.
// Latency: response pulse in X1, 6 clocks after the accepting X3.
// Backpressure: requests held until req_ready; responses are unconditional pulses.
module mcs4_rom_sequencer
   import mcs4::*;
#(
   parameter int NUM_ROMS = 16,
   parameter bit RR_EN    = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req_valid,
   input  rom_addr_t [1:0]     req_addr,
   output logic [1:0]          req_ready,
   output logic                rsp_valid,
   output logic                rsp_id,
   output byte_t               rsp_data,
   output logic                rsp_err,
   output logic                sync,
   output logic                cm_rom,
   output instr_cyc_t          phase,
   output char_t               dbus_out,
   input  char_t               dbus_in
);

   localparam logic [4:0] RomLimit = (NUM_ROMS > Max_roms) ? 5'(Max_roms) : 5'(NUM_ROMS);

   logic      active_q;
   rom_addr_t addr_q;
   logic      id_q;
   char_t     hi_q;
   logic      in_x3;
   logic      gnt_vld;
   logic      gnt_id;
   logic      err_addr;

   assign in_x3    = (phase == X3);
   assign sync     = in_x3;
   assign err_addr = ({1'b0, chip_of(addr_q)} >= RomLimit);

   mcs4_rr_arbiter #(
      .RR_EN (RR_EN)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .en      (in_x3),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

   // Phase sits at X3 throughout reset, so the accept pulse is masked by rst_n.
   always_comb begin
      req_ready = 2'b00;
      if (rst_n && in_x3 && gnt_vld) begin
         req_ready[gnt_id] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase     <= X3;
         active_q  <= 1'b0;
         addr_q    <= '0;
         id_q      <= 1'b0;
         hi_q      <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         phase     <= instr_cyc_t'(phase + 3'd1);
         rsp_valid <= 1'b0;
         if (in_x3) begin
            active_q <= gnt_vld;
            if (gnt_vld) begin
               addr_q <= req_addr[gnt_id];
               id_q   <= gnt_id;
            end
         end
         if (active_q && (phase == M1)) begin
            hi_q <= dbus_in;
         end
         if (active_q && (phase == M2)) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_err   <= err_addr;
            rsp_data  <= err_addr ? 8'h00 : {hi_q, dbus_in};
         end
      end
   end

   // Missing chips are still sequenced on the bus; only the returned data is suppressed.
   always_comb begin
      dbus_out = '0;
      cm_rom   = 1'b0;
      if (active_q) begin
         case (phase)
            A1: dbus_out = addr_q[3:0];
            A2: dbus_out = addr_q[7:4];
            A3: begin
               dbus_out = addr_q[11:8];
               cm_rom   = 1'b1;
            end
            X2: begin
               dbus_out = addr_q[11:8];
               cm_rom   = 1'b1;
            end
            default: dbus_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mcs4_rom_sequencer.sv
// Bench for mcs4_rom_sequencer: round-robin and fixed-priority instances with behavioural ROMs.
module tb_mcs4_rom_sequencer;
   import mcs4::*;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      req_valid = 2'b00;
   rom_addr_t [1:0] req_addr = '0;

   logic [1:0] rr_ready, fp_ready;
   logic       rr_rsp_valid, rr_rsp_id, rr_rsp_err, rr_sync, rr_cm;
   logic       fp_rsp_valid, fp_rsp_id, fp_rsp_err, fp_sync, fp_cm;
   byte_t      rr_rsp_data, fp_rsp_data;
   instr_cyc_t rr_phase, fp_phase;
   char_t      rr_dout, rr_din, fp_dout, fp_din;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   byte_t rom_mem [4096];

   typedef struct {
      int        due;
      logic      id;
      rom_addr_t addr;
   } exp_t;
   exp_t rq[$];
   int   exp_ph = 7;
   logic last_g = 1'b1;

   always #5 clk = ~clk;

   mcs4_rom_sequencer #(.NUM_ROMS(2), .RR_EN(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(rr_ready), .rsp_valid(rr_rsp_valid), .rsp_id(rr_rsp_id),
      .rsp_data(rr_rsp_data), .rsp_err(rr_rsp_err), .sync(rr_sync), .cm_rom(rr_cm),
      .phase(rr_phase), .dbus_out(rr_dout), .dbus_in(rr_din)
   );

   mcs4_rom_sequencer #(.NUM_ROMS(2), .RR_EN(1'b0)) u_fp (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(fp_ready), .rsp_valid(fp_rsp_valid), .rsp_id(fp_rsp_id),
      .rsp_data(fp_rsp_data), .rsp_err(fp_rsp_err), .sync(fp_sync), .cm_rom(fp_cm),
      .phase(fp_phase), .dbus_out(fp_dout), .dbus_in(fp_din)
   );

   // Behavioural 4001 bank (chips 0 and 1): latch address in A1..A3, answer in M1/M2 if selected.
   rom_addr_t rr_lat = '0, fp_lat = '0;
   logic      rr_sel = 1'b0, fp_sel = 1'b0;

   always @(posedge clk) begin
      case (rr_phase)
         A1: rr_lat[3:0] <= rr_dout;
         A2: rr_lat[7:4] <= rr_dout;
         A3: begin rr_lat[11:8] <= rr_dout; rr_sel <= rr_cm; end
         default: ;
      endcase
      case (fp_phase)
         A1: fp_lat[3:0] <= fp_dout;
         A2: fp_lat[7:4] <= fp_dout;
         A3: begin fp_lat[11:8] <= fp_dout; fp_sel <= fp_cm; end
         default: ;
      endcase
   end

   always_comb begin
      rr_din = 4'h0;
      if (rr_sel && rr_lat[11:8] < 4'd2) begin
         if (rr_phase == M1) rr_din = rom_mem[rr_lat][7:4];
         else if (rr_phase == M2) rr_din = rom_mem[rr_lat][3:0];
      end
   end

   always_comb begin
      fp_din = 4'h0;
      if (fp_sel && fp_lat[11:8] < 4'd2) begin
         if (fp_phase == M1) fp_din = rom_mem[fp_lat][7:4];
         else if (fp_phase == M2) fp_din = rom_mem[fp_lat][3:0];
      end
   end

   function automatic byte_t exp_data(input rom_addr_t a);
      return (a[11:8] < 4'd2) ? rom_mem[a] : 8'h00;
   endfunction

   // Reference model: phase ring, grant rules, and a due-time queue of responses.
   always @(negedge clk) begin : monitor
      logic [1:0] exp_rdy, exp_fpr;
      logic       w;
      cyc++;
      if (!rst_n) begin
         exp_ph = 7;
         last_g = 1'b1;
         rq.delete();
         tests_run++;
         if (rr_phase !== X3 || rr_sync !== 1'b1 || rr_ready !== 2'b00 || rr_rsp_valid !== 1'b0 ||
             rr_dout !== 4'h0 || rr_cm !== 1'b0 || rr_rsp_data !== 8'h00 || fp_ready !== 2'b00) begin
            tests_failed++;
            $display("FAIL mon_reset_state phase=%0d sync=%b rdy=%b rv=%b dout=%h cm=%b data=%h fp_rdy=%b",
                     rr_phase, rr_sync, rr_ready, rr_rsp_valid, rr_dout, rr_cm, rr_rsp_data, fp_ready);
         end
      end else begin
         tests_run++;
         if (rr_phase !== instr_cyc_t'(exp_ph) || rr_sync !== (exp_ph == 7)) begin
            tests_failed++;
            $display("FAIL mon_phase cyc=%0d got=%0d/sync=%b want=%0d", cyc, rr_phase, rr_sync, exp_ph);
         end
         exp_rdy = 2'b00;
         exp_fpr = 2'b00;
         if (exp_ph == 7 && req_valid != 2'b00) begin
            if (req_valid == 2'b11) w = ~last_g;
            else w = ~req_valid[0];
            exp_rdy[w] = 1'b1;
            last_g = w;
            rq.push_back('{due: cyc + 6, id: w, addr: req_addr[w]});
            exp_fpr[~req_valid[0]] = 1'b1;
         end
         tests_run++;
         if (rr_ready !== exp_rdy || fp_ready !== exp_fpr) begin
            tests_failed++;
            $display("FAIL mon_grant cyc=%0d rr=%b want=%b fp=%b want=%b", cyc, rr_ready, exp_rdy, fp_ready, exp_fpr);
         end
         tests_run++;
         if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rr_rsp_valid !== 1'b1 || rr_rsp_id !== rq[0].id || rr_rsp_data !== exp_data(rq[0].addr) ||
                rr_rsp_err !== (rq[0].addr[11:8] >= 4'd2)) begin
               tests_failed++;
               $display("FAIL mon_rsp cyc=%0d addr=%h got v=%b id=%b d=%h e=%b want id=%b d=%h",
                        cyc, rq[0].addr, rr_rsp_valid, rr_rsp_id, rr_rsp_data, rr_rsp_err, rq[0].id, exp_data(rq[0].addr));
            end
            void'(rq.pop_front());
         end else if (rr_rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mon_spurious_rsp cyc=%0d got=%b want=0", cyc, rr_rsp_valid);
         end
         exp_ph = (exp_ph + 1) % Cycle_len;
      end
   end

   task automatic wait_ph(input instr_cyc_t p);
      int n = 0;
      @(negedge clk);
      while (rr_phase !== p && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (rr_phase !== p) begin
         tests_run++;
         tests_failed++;
         $display("FAIL wait_phase got=%0d want=%0d", rr_phase, p);
      end
   endtask

   task automatic test_reset;
      req_valid = 2'b11;
      req_addr[0] = 12'h001;
      req_addr[1] = 12'h002;
      @(negedge clk);
      tests_run++;
      if (rr_phase !== X3 || rr_sync !== 1'b1 || rr_ready !== 2'b00 || rr_rsp_valid !== 1'b0 ||
          rr_rsp_id !== 1'b0 || rr_rsp_err !== 1'b0 || rr_rsp_data !== 8'h00 || rr_dout !== 4'h0 || rr_cm !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs phase=%0d sync=%b rdy=%b rv=%b id=%b err=%b data=%h dout=%h cm=%b",
                  rr_phase, rr_sync, rr_ready, rr_rsp_valid, rr_rsp_id, rr_rsp_err, rr_rsp_data, rr_dout, rr_cm);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      tests_run++;
      if (rr_phase !== X3 || rr_sync !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_first_x3 phase=%0d sync=%b want X3/1", rr_phase, rr_sync);
      end
      @(negedge clk);
      tests_run++;
      if (rr_phase !== A1 || rr_sync !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_then_a1 phase=%0d sync=%b want A1/0", rr_phase, rr_sync);
      end
   endtask

   task automatic test_rr;
      int   pulses;
      logic last_id;
      wait_ph(X2);
      @(posedge clk); #1;
      req_valid = 2'b11;
      req_addr[0] = 12'h012;
      req_addr[1] = 12'h1AB;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (rr_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10) || fp_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL rr_grant k=%0d rr=%b fp=%b want rr=%b fp=01", k, rr_ready, fp_ready,
                     (k % 2 == 0) ? 2'b01 : 2'b10);
         end
         pulses = 0;
         last_id = 1'b0;
         repeat (7) begin
            @(negedge clk);
            if (rr_rsp_valid) begin
               pulses++;
               last_id = rr_rsp_id;
            end
         end
         tests_run++;
         if (pulses != 1 || last_id !== k[0]) begin
            tests_failed++;
            $display("FAIL rr_rsp_per_cycle k=%0d pulses=%0d id=%b want 1/%b", k, pulses, last_id, k[0]);
         end
         if (k < 3) @(negedge clk);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
   endtask

   task automatic test_idle;
      int syncs = 0;
      int bad = 0;
      wait_ph(X3);
      repeat (3 * Cycle_len) begin
         @(negedge clk);
         if (rr_sync) syncs++;
         if (rr_dout !== 4'h0 || rr_cm !== 1'b0 || rr_rsp_valid !== 1'b0 || rr_ready !== 2'b00) bad++;
      end
      tests_run++;
      if (syncs != 3) begin
         tests_failed++;
         $display("FAIL idle_sync_count got=%0d want=3", syncs);
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL idle_bus_quiet bad_cycles=%0d want=0", bad);
      end
   endtask

   task automatic run_fetch_check(input string name, input logic port, input rom_addr_t a,
                                  input byte_t want_d, input logic want_e);
      char_t exp_d [7];
      logic  exp_cm [7];
      int    lat = 0;
      exp_d = '{a[3:0], a[7:4], a[11:8], 4'h0, 4'h0, 4'h0, a[11:8]};
      exp_cm = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      wait_ph(X2);
      @(posedge clk); #1;
      req_valid[port] = 1'b1;
      req_addr[port] = a;
      @(negedge clk);
      tests_run++;
      if (rr_ready !== (port ? 2'b10 : 2'b01)) begin
         tests_failed++;
         $display("FAIL %s_ready got=%b port=%0d", name, rr_ready, port);
      end
      @(posedge clk); #1;
      req_valid[port] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) @(negedge clk);
         else @(negedge clk);
         tests_run++;
         if (rr_dout !== exp_d[i] || rr_cm !== exp_cm[i]) begin
            tests_failed++;
            $display("FAIL %s_bus step=%0d dout=%h cm=%b want %h/%b", name, i, rr_dout, rr_cm, exp_d[i], exp_cm[i]);
         end
         if (rr_rsp_valid && lat == 0) lat = i + 1;
      end
      tests_run++;
      if (lat != 6 || rr_rsp_data !== want_d || rr_rsp_id !== port || rr_rsp_err !== want_e) begin
         tests_failed++;
         $display("FAIL %s_rsp lat=%0d data=%h id=%b err=%b want 6/%h/%b/%b",
                  name, lat, rr_rsp_data, rr_rsp_id, rr_rsp_err, want_d, port, want_e);
      end
   endtask

   task automatic test_error;
      run_fetch_check("error", 1'b1, 12'h3FF, 8'h00, 1'b1);
   endtask

   task automatic test_basic_fetch;
      run_fetch_check("basic", 1'b0, 12'h005, 8'hA7, 1'b0);
   endtask

   task automatic test_async_reset;
      int pulses = 0;
      wait_ph(X2);
      @(posedge clk); #1;
      req_valid[0] = 1'b1;
      req_addr[0] = 12'h005;
      wait_ph(M1);
      #1 rst_n = 1'b0;
      #1;
      tests_run++;
      if (rr_phase !== X3 || rr_sync !== 1'b1 || rr_ready !== 2'b00 || rr_dout !== 4'h0 || rr_cm !== 1'b0 ||
          rr_rsp_valid !== 1'b0 || rr_rsp_data !== 8'h00 || rr_rsp_id !== 1'b0 || rr_rsp_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset_immediate phase=%0d sync=%b rdy=%b dout=%h cm=%b rv=%b data=%h id=%b err=%b",
                  rr_phase, rr_sync, rr_ready, rr_dout, rr_cm, rr_rsp_valid, rr_rsp_data, rr_rsp_id, rr_rsp_err);
      end
      repeat (4) begin
         @(negedge clk);
         if (rr_rsp_valid) pulses++;
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (rr_phase !== X3 || rr_sync !== 1'b1 || rr_ready !== 2'b01) begin
         tests_failed++;
         $display("FAIL async_release phase=%0d sync=%b rdy=%b want X3/1/01", rr_phase, rr_sync, rr_ready);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (5) begin
         @(negedge clk);
         if (rr_rsp_valid) pulses++;
      end
      tests_run++;
      if (pulses != 0) begin
         tests_failed++;
         $display("FAIL async_dropped_fetch early_pulses=%0d want=0", pulses);
      end
      @(negedge clk);
      tests_run++;
      if (rr_rsp_valid !== 1'b1 || rr_rsp_data !== 8'hA7 || rr_rsp_id !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_new_fetch v=%b data=%h id=%b want 1/a7/0", rr_rsp_valid, rr_rsp_data, rr_rsp_id);
      end
   endtask

   task automatic test_drop;
      int grants = 0;
      int pulses = 0;
      wait_ph(M1);
      @(posedge clk); #1;
      req_valid[1] = 1'b1;
      req_addr[1] = 12'h0C3;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      repeat (16) begin
         @(negedge clk);
         if (rr_ready != 2'b00) grants++;
         if (rr_rsp_valid) pulses++;
      end
      tests_run++;
      if (grants != 0 || pulses != 0) begin
         tests_failed++;
         $display("FAIL drop_before_x3 grants=%0d pulses=%0d want 0/0", grants, pulses);
      end
   endtask

   task automatic test_random;
      logic [1:0] acc;
      repeat (40 * Cycle_len) begin
         @(negedge clk);
         acc = rr_ready;
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            if (req_valid[p] && acc[p]) begin
               req_valid[p] = 1'($urandom_range(0, 1));
               if (req_valid[p]) req_addr[p] = rom_addr_t'($urandom_range(0, 12'h2FF));
            end else if (!req_valid[p] && $urandom_range(0, 7) == 0) begin
               req_valid[p] = 1'b1;
               req_addr[p] = rom_addr_t'($urandom_range(0, 12'h2FF));
            end
         end
      end
      req_valid = 2'b00;
      repeat (2 * Cycle_len) @(negedge clk);
      tests_run++;
      if (rq.size() != 0) begin
         tests_failed++;
         $display("FAIL random_drain outstanding=%0d want=0", rq.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
      rom_mem[12'h005] = 8'hA7;
      test_reset;
      test_rr;
      test_idle;
      test_error;
      test_basic_fetch;
      test_async_reset;
      test_drop;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mcs4_rom_sequencer.md
Name: mcs4_rom_sequencer

Overview:
- Master bus sequencer for the MCS-4 4-bit ROM bus.
- Generates the 8-phase instruction cycle (A1,A2,A3,M1,M2,X1,X2,X3) and the sync strobe that realigns ROM chips.
- Arbitrates one ROM fetch per instruction cycle between two requesters: port 0 (CPU fetch) and port 1 (host/debug loader).
- Drives the 12-bit address as three nibbles, collects the returned byte in M1/M2, and returns it with a requester ID.

Parameters:
NUM_ROMS, 16, number of populated ROM chips; chip IDs >= NUM_ROMS flag rsp_err.
RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  2  per-port fetch request; must be held until accepted
req_addr  in  2x12  per-port ROM address {chip[11:8], byte[7:0]}
req_ready  out  2  per-port accept pulse; at most one bit high
rsp_valid  out  1  one-cycle pulse, fetched byte valid
rsp_id  out  1  port that owns the response
rsp_data  out  8  fetched byte {M1 nibble, M2 nibble}
rsp_err  out  1  chip ID >= NUM_ROMS; rsp_data forced to 0x00
sync  out  1  high during X3
cm_rom  out  1  ROM command strobe, high in A3 and X2 of an active cycle
phase  out  mcs4::instr_cyc_t  current phase, for observers
dbus_out  out  4  nibble driven onto the ROM bus
dbus_in  in  4  OR of all ROM dbus_out

Behaviour:
- Phase counter: 3-bit, increments every clk, wraps X3->A1. Reset value X3, so the first cycle after reset release is X3 with sync=1, followed by A1.
- sync = (phase==X3), combinational. ROMs clear their counters on it and see A1 next cycle.
- Arbitration is evaluated only in X3:
  - Candidates are the ports with req_valid=1.
  - RR_EN=1: if both request, grant the port not granted last; the last-grant pointer resets to 1, so port 0 wins the first tie.
  - RR_EN=0: port 0 always wins.
  - Winner gets req_ready=1 for that X3 cycle only. req_ready=0 in all other phases and during reset.
  - On handshake, latch addr, id and active=1 at the X3->A1 edge.
- No request in X3: active=0 for the whole next cycle; dbus_out=0, cm_rom=0, no response.
- Active cycle drive:
  - A1: addr[3:0]. A2: addr[7:4]. A3: addr[11:8] with cm_rom=1.
  - M1, M2: dbus_out=0 (ROM drives).
  - X2: addr[11:8] with cm_rom=1 (chip select).
  - X1, X3: 0.
- Capture: dbus_in sampled at end of M1 -> hi nibble, end of M2 -> lo nibble.
- Response timing:
  - rsp_valid is high in X1 of the same instruction cycle; latency from the accepting X3 is 6 clocks.
  - rsp_data, rsp_id and rsp_err are held until the next response. No backpressure: the requester must take the pulse.
- Error case: chip >= NUM_ROMS is still sequenced on the bus; rsp_err=1 and rsp_data=0x00.
- Throughput: one fetch per 8 clocks; a port whose req is held continuously is accepted every cycle it wins.
- req_valid dropped before X3: not granted, no response. req_addr is sampled only at the handshake.
- Async reset mid-cycle:
  - Immediately: phase=X3, active=0, rsp_valid=0, req_ready=0, dbus_out=0, cm_rom=0, rsp_data=0, rsp_id=0, rsp_err=0, last-grant=1.
  - The in-flight fetch is dropped with no response.
- Reset values of all outputs are as listed above; sync=1 during reset.

Decomposition:
- mcs4 package:
  - existing instr_cyc_t, char_t, byte_t
  - new rom_addr_t (12-bit)
  - constant Cycle_len=8
  - constant Max_roms=16
- One sub-module: mcs4_rr_arbiter (2-port, RR_EN parameter, advances its pointer only on an enable pulse at X3).

Test Plan:
- Bench setup: two i4001 instances, one of them with rom[0x05]=0xA7. Port 0 requests 0x005 -> dbus_out sequence 5,0,0 in A1..A3; cm_rom in A3 and X2; rsp_valid 6 clocks after req_ready with rsp_data=0xA7, rsp_id=0, rsp_err=0.
- Both ports held valid for 4 instruction cycles, RR_EN=1 -> grants 0,1,0,1, exactly one X1 rsp_valid per cycle. With RR_EN=0 -> grants 0,0,0,0.
- Idle: no requests for 3 cycles -> sync every 8 clocks, dbus_out=0, cm_rom=0, rsp_valid never high.
- NUM_ROMS=2, request 0x3FF -> bus sequenced with nibbles F,F,3, then rsp_err=1 and rsp_data=0x00.
- Assert rst_n low during M1 of an active fetch -> outputs go to reset values immediately, no rsp_valid follows. After release: X3 with sync=1, then A1; a new request completes normally.
- Port 1 raises req_valid in M2 and drops it in X1 -> never granted, no response.
